issue_ctrl: RTL and testbench

- Dispatch sequencer between the fetcher and the decode stage of the Tomasulo core.
- Latches one fetched instruction and presents it to decode.
- Tracks ROB, RS and SLB occupancy with credit counters, and fires a single write strobe to ROB plus RS or SLB only when every needed slot is free.
- Back-pressures the fetcher and discards in-flight state on a misprediction flush.

---
 rtl/issue_ctrl_pkg.sv | 43 ++++
 rtl/issue_ctrl_credit_counter.sv | 42 ++++
 rtl/issue_ctrl.sv | 114 +++++++++++
 tb/tb_issue_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared opcode constants, FSM/target encodings and the opcode-to-target
// classifier used by the dispatch sequencer.
package issue_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] ZERO_DATA = '0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HELD,
    ST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    TGT_ILLEGAL,
    TGT_RS,
    TGT_SLB
  } target_t;

  function automatic target_t classify(input logic [6:0] opcode);
    target_t t;
    case (opcode)
      OP_LOAD, OP_STORE:                    t = TGT_SLB;
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_I_TYPE, OP_R_TYPE:      t = TGT_RS;
      default:                              t = TGT_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/issue_ctrl_credit_counter.sv
// Saturating occupancy counter: +1 on inc, -1 on dec, clear on clr,
// frozen while en is low.
module credit_counter
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      if (clr) begin
        count <= '0;
      end else if (inc && !dec) begin
        if (count < MAX) count <= count + CNT_W'(1);
      end else if (dec && !inc) begin
        if (count != '0) count <= count - CNT_W'(1);
      end
    end
  end

  assign full = (count >= MAX);

  // A release with nothing outstanding means the producer lost track of credits.
  a_no_release_at_zero: assert property (
    @(posedge clk) disable iff (!rst) (en && !clr && dec && !inc) |-> (count != '0)
  );

endmodule

// File: rtl/issue_ctrl.sv
// Dispatch sequencer: holds one fetched instruction, issues it to ROB plus
// RS or SLB once credits allow, and recovers for one cycle after a flush.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned SLB_SIZE = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               in_fetch_valid,
  input  logic [INSTR_W-1:0] in_fetch_instr,
  input  logic [ADDR_W-1:0]  in_fetch_pc,
  input  logic               in_fetch_jump_ce,
  output logic               out_fetch_ready,
  output logic [INSTR_W-1:0] out_dec_instr,
  output logic [ADDR_W-1:0]  out_dec_pc,
  output logic               out_dec_jump_ce,
  output logic               out_rob_we,
  output logic               out_rs_we,
  output logic               out_slb_we,
  input  logic               in_rob_commit,
  input  logic               in_rs_release,
  input  logic               in_slb_release,
  input  logic               in_flush,
  output logic               out_stall
);

  state_t           state, state_nxt;
  target_t          target;
  logic             held, legal, can_issue, go, issue, drop, accept;
  logic             rob_full, rs_full, slb_full;
  logic [CNT_W-1:0] rob_cnt, rs_cnt, slb_cnt;

  assign held      = (state == ST_HELD);
  assign target    = classify(out_dec_instr[6:0]);
  assign legal     = (target != TGT_ILLEGAL);
  assign can_issue = held && !rob_full && ((target == TGT_RS) ? !rs_full : !slb_full);
  assign go        = rdy && !in_flush;
  assign issue     = go && can_issue && legal;
  // An illegal opcode frees the holding slot without touching any resource.
  assign drop      = go && held && !legal;

  assign out_fetch_ready = rst && go && ((state == ST_EMPTY) || issue || drop);
  assign accept          = in_fetch_valid && out_fetch_ready;

  assign out_rob_we = issue;
  assign out_rs_we  = issue && (target == TGT_RS);
  assign out_slb_we = issue && (target == TGT_SLB);
  assign out_stall  = held && legal && !can_issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rdy) begin
      if (in_flush) begin
        state_nxt = ST_FLUSH;
      end else begin
        unique case (state)
          ST_EMPTY: if (accept) state_nxt = ST_HELD;
          ST_HELD:  if (issue || drop) state_nxt = accept ? ST_HELD : ST_EMPTY;
          ST_FLUSH: state_nxt = ST_EMPTY;
          default:  state_nxt = ST_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_dec_instr   <= ZERO_DATA;
      out_dec_pc      <= '0;
      out_dec_jump_ce <= 1'b0;
    end else if (rdy) begin
      if (in_flush) begin
        out_dec_instr   <= ZERO_DATA;
        out_dec_pc      <= '0;
        out_dec_jump_ce <= 1'b0;
      end else if (accept) begin
        out_dec_instr   <= in_fetch_instr;
        out_dec_pc      <= in_fetch_pc;
        out_dec_jump_ce <= in_fetch_jump_ce;
      end
    end
  end

  credit_counter #(.SIZE(ROB_SIZE), .CNT_W(CNT_W)) u_rob_cnt (
    .clk(clk), .rst(rst), .en(rdy), .inc(out_rob_we), .dec(in_rob_commit),
    .clr(in_flush), .full(rob_full), .count(rob_cnt)
  );

  credit_counter #(.SIZE(RS_SIZE), .CNT_W(CNT_W)) u_rs_cnt (
    .clk(clk), .rst(rst), .en(rdy), .inc(out_rs_we), .dec(in_rs_release),
    .clr(in_flush), .full(rs_full), .count(rs_cnt)
  );

  credit_counter #(.SIZE(SLB_SIZE), .CNT_W(CNT_W)) u_slb_cnt (
    .clk(clk), .rst(rst), .en(rdy), .inc(out_slb_we), .dec(in_slb_release),
    .clr(in_flush), .full(slb_full), .count(slb_cnt)
  );

  a_cnt_bounded: assert property (
    @(posedge clk) disable iff (!rst)
      (rob_cnt <= CNT_W'(ROB_SIZE)) && (rs_cnt <= CNT_W'(RS_SIZE)) && (slb_cnt <= CNT_W'(SLB_SIZE))
  );

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus a randomized
// run against a transaction-level occupancy model.
module tb_issue_ctrl;

  localparam int SZ = 16;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] SW   = 32'h0000_2023;
  localparam logic [31:0] ILL  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst, rdy, in_fetch_valid, in_fetch_jump_ce;
  logic [31:0] in_fetch_instr, in_fetch_pc;
  logic        out_fetch_ready, out_dec_jump_ce, out_rob_we, out_rs_we, out_slb_we, out_stall;
  logic [31:0] out_dec_instr, out_dec_pc;
  logic        in_rob_commit, in_rs_release, in_slb_release, in_flush;

  always #5 clk = ~clk;

  issue_ctrl #(.ROB_SIZE(SZ), .RS_SIZE(SZ), .SLB_SIZE(SZ), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetch_valid(in_fetch_valid), .in_fetch_instr(in_fetch_instr),
    .in_fetch_pc(in_fetch_pc), .in_fetch_jump_ce(in_fetch_jump_ce),
    .out_fetch_ready(out_fetch_ready), .out_dec_instr(out_dec_instr),
    .out_dec_pc(out_dec_pc), .out_dec_jump_ce(out_dec_jump_ce),
    .out_rob_we(out_rob_we), .out_rs_we(out_rs_we), .out_slb_we(out_slb_we),
    .in_rob_commit(in_rob_commit), .in_rs_release(in_rs_release),
    .in_slb_release(in_slb_release), .in_flush(in_flush), .out_stall(out_stall)
  );

  logic [4:0]  obs;
  logic [14:0] cnts;
  assign obs  = {out_fetch_ready, out_rob_we, out_rs_we, out_slb_we, out_stall};
  assign cnts = {dut.rob_cnt, dut.rs_cnt, dut.slb_cnt};

  int checks = 0;
  int errors = 0;

  // Reference model: one optional held instruction, a recovery flag and
  // three plain occupancy numbers.
  bit          m_held, m_recover, m_jump;
  logic [31:0] m_instr, m_pc;
  int          m_rob, m_rs, m_slb;
  bit          e_ready, e_rob, e_rs, e_slb, e_stall, e_drop;

  // 0 = illegal, 1 = reservation station, 2 = store/load buffer
  function automatic int kind(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h23: return 2;
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int bump(input int c, input bit up, input bit down);
    if (up && !down && c < SZ) return c + 1;
    if (down && !up && c > 0)  return c - 1;
    return c;
  endfunction

  task automatic model_reset();
    m_held = 0; m_recover = 0; m_jump = 0; m_instr = '0; m_pc = '0;
    m_rob = 0; m_rs = 0; m_slb = 0;
  endtask

  task automatic model_eval();
    int  k;
    bit  room, live;
    k       = kind(m_instr);
    room    = (m_rob < SZ) && ((k == 1) ? (m_rs < SZ) : (m_slb < SZ));
    live    = rdy && !in_flush;
    e_rob   = live && m_held && (k != 0) && room;
    e_rs    = e_rob && (k == 1);
    e_slb   = e_rob && (k == 2);
    e_drop  = live && m_held && (k == 0);
    e_ready = live && !m_recover && (!m_held || e_rob || e_drop);
    e_stall = m_held && (k != 0) && !room;
  endtask

  task automatic model_advance();
    if (!rdy) return;
    if (in_flush) begin
      m_held = 0; m_recover = 1; m_instr = '0; m_pc = '0; m_jump = 0;
      m_rob = 0; m_rs = 0; m_slb = 0;
      return;
    end
    m_recover = 0;
    m_rob = bump(m_rob, e_rob, in_rob_commit);
    m_rs  = bump(m_rs,  e_rs,  in_rs_release);
    m_slb = bump(m_slb, e_slb, in_slb_release);
    if (in_fetch_valid && e_ready) begin
      m_held = 1; m_instr = in_fetch_instr; m_pc = in_fetch_pc; m_jump = in_fetch_jump_ce;
    end else if (e_rob || e_drop) begin
      m_held = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1; in_fetch_valid = 0; in_fetch_instr = '0; in_fetch_pc = '0; in_fetch_jump_ce = 0;
    in_rob_commit = 0; in_rs_release = 0; in_slb_release = 0; in_flush = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    model_reset();
    in_fetch_valid = 1; in_fetch_instr = ADDI;
    @(posedge clk); #3;
    checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 5'b00000); end
    checks++;
    if (cnts !== 15'd0 || out_dec_instr !== 32'd0) begin
      errors++; $display("FAIL reset_state: cnts %h instr %h expected 0 0", cnts, out_dec_instr);
    end
    apply_reset();
  endtask

  task automatic test_addi();
    apply_reset();
    in_fetch_valid = 1; in_fetch_instr = ADDI; in_fetch_pc = 32'h0;
    settle();
    checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL addi_accept: got %b expected %b", obs, 5'b10000); end
    tick();
    in_fetch_valid = 0;
    settle();
    checks++;
    if (obs !== 5'b11100) begin errors++; $display("FAIL addi_strobe: got %b expected %b", obs, 5'b11100); end
    checks++;
    if (out_dec_instr !== ADDI || out_dec_pc !== 32'h0) begin
      errors++; $display("FAIL addi_held: got %h/%h expected %h/0", out_dec_instr, out_dec_pc, ADDI);
    end
    tick();
    settle();
    checks++;
    if (cnts !== {5'd1, 5'd1, 5'd0}) begin errors++; $display("FAIL addi_counts: got %h expected %h", cnts, {5'd1, 5'd1, 5'd0}); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    in_fetch_valid = 1; in_fetch_instr = LW;
    for (int i = 0; i <= 16; i++) begin
      in_fetch_pc = 32'(i * 4);
      settle();
      checks++;
      if (obs !== ((i == 0) ? 5'b10000 : 5'b11010)) begin
        errors++; $display("FAIL b2b_issue[%0d]: got %b expected %b", i, obs, (i == 0) ? 5'b10000 : 5'b11010);
      end
      tick();
    end
    in_fetch_valid = 0;
    settle();
    checks++;
    if (obs !== 5'b00001 || cnts !== {5'd16, 5'd0, 5'd16} || out_dec_pc !== 32'd64) begin
      errors++; $display("FAIL b2b_full_stall: obs %b cnts %h pc %h expected 00001 %h 40", obs, cnts, out_dec_pc, {5'd16, 5'd0, 5'd16});
    end
    in_rob_commit = 1; in_slb_release = 1;
    tick();
    in_rob_commit = 0; in_slb_release = 0;
    settle();
    checks++;
    if (obs !== 5'b11010 || cnts !== {5'd15, 5'd0, 5'd15}) begin
      errors++; $display("FAIL b2b_resume: obs %b cnts %h expected 11010 %h", obs, cnts, {5'd15, 5'd0, 5'd15});
    end
    tick();
    // refill to full, then overlap one release with one issue
    in_fetch_valid = 1; in_fetch_pc = 32'h100;
    settle(); tick();
    in_fetch_valid = 0;
    in_rob_commit = 1; in_slb_release = 1;
    tick();
    settle();
    checks++;
    if (obs !== 5'b11010 || cnts !== {5'd15, 5'd0, 5'd15}) begin
      errors++; $display("FAIL b2b_issue_with_release: obs %b cnts %h expected 11010 %h", obs, cnts, {5'd15, 5'd0, 5'd15});
    end
    tick();
    in_rob_commit = 0; in_slb_release = 0;
    settle();
    checks++;
    if (cnts !== {5'd15, 5'd0, 5'd15}) begin
      errors++; $display("FAIL b2b_simul_inc_dec: got %h expected %h", cnts, {5'd15, 5'd0, 5'd15});
    end
    in_fetch_valid = 1; in_fetch_pc = 32'h200;
    tick();
    settle();
    tick();
    in_fetch_valid = 0;
    settle();
    checks++;
    if (obs !== 5'b00001 || cnts !== {5'd16, 5'd0, 5'd16}) begin
      errors++; $display("FAIL b2b_no_overflow: obs %b cnts %h expected 00001 %h", obs, cnts, {5'd16, 5'd0, 5'd16});
    end
  endtask

  task automatic test_flush();
    apply_reset();
    in_fetch_valid = 1; in_fetch_instr = ADDI;
    settle(); tick();
    in_fetch_instr = SW; in_fetch_pc = 32'h4;
    settle(); tick();
    in_fetch_valid = 0; in_flush = 1; in_rob_commit = 1; in_rs_release = 1;
    settle();
    checks++;
    if (obs !== 5'b00000 || cnts !== {5'd1, 5'd1, 5'd0}) begin
      errors++; $display("FAIL flush_suppress: obs %b cnts %h expected 00000 %h", obs, cnts, {5'd1, 5'd1, 5'd0});
    end
    tick();
    in_flush = 0; in_rob_commit = 0; in_rs_release = 0;
    in_fetch_valid = 1; in_fetch_instr = ADDI; in_fetch_pc = 32'h80;
    settle();
    checks++;
    if (obs !== 5'b00000 || cnts !== 15'd0 || out_dec_instr !== 32'd0) begin
      errors++; $display("FAIL flush_recover: obs %b cnts %h instr %h expected 00000 0 0", obs, cnts, out_dec_instr);
    end
    tick();
    settle();
    checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL flush_empty_after: got %b expected %b", obs, 5'b10000); end
    tick();
    in_fetch_valid = 0;
    settle();
    checks++;
    if (obs !== 5'b11100 || out_dec_pc !== 32'h80) begin
      errors++; $display("FAIL flush_reissue: obs %b pc %h expected 11100 80", obs, out_dec_pc);
    end
    tick();
  endtask

  task automatic test_illegal();
    apply_reset();
    in_fetch_valid = 1; in_fetch_instr = ADDI;
    settle(); tick();
    in_fetch_instr = ILL; in_fetch_pc = 32'h4;
    settle(); tick();
    in_fetch_instr = ADDI; in_fetch_pc = 32'h8;
    settle();
    checks++;
    if (obs !== 5'b10000 || cnts !== {5'd1, 5'd1, 5'd0}) begin
      errors++; $display("FAIL illegal_drop: obs %b cnts %h expected 10000 %h", obs, cnts, {5'd1, 5'd1, 5'd0});
    end
    tick();
    in_fetch_valid = 0;
    settle();
    checks++;
    if (obs !== 5'b11100 || out_dec_pc !== 32'h8 || cnts !== {5'd1, 5'd1, 5'd0}) begin
      errors++; $display("FAIL illegal_next: obs %b pc %h cnts %h expected 11100 8 %h", obs, out_dec_pc, cnts, {5'd1, 5'd1, 5'd0});
    end
    tick();
  endtask

  task automatic test_rdy_freeze();
    apply_reset();
    in_fetch_valid = 1; in_fetch_instr = ADDI;
    settle(); tick();
    in_fetch_pc = 32'h4;
    settle(); tick();
    rdy = 0; in_fetch_instr = LW; in_fetch_pc = 32'h40; in_rob_commit = 1; in_rs_release = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (obs !== 5'b00000 || cnts !== {5'd1, 5'd1, 5'd0} || out_dec_pc !== 32'h4) begin
        errors++; $display("FAIL rdy_frozen[%0d]: obs %b cnts %h pc %h expected 00000 %h 4", i, obs, cnts, out_dec_pc, {5'd1, 5'd1, 5'd0});
      end
      tick();
    end
    rdy = 1; in_fetch_valid = 0; in_rob_commit = 0; in_rs_release = 0;
    settle();
    checks++;
    if (obs !== 5'b11100) begin errors++; $display("FAIL rdy_resume: got %b expected %b", obs, 5'b11100); end
    tick();
    settle();
    checks++;
    if (cnts !== {5'd2, 5'd2, 5'd0}) begin errors++; $display("FAIL rdy_resume_counts: got %h expected %h", cnts, {5'd2, 5'd2, 5'd0}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_fetch_valid = 1; in_fetch_instr = ADDI;
    settle(); tick();
    in_fetch_instr = LW; in_fetch_pc = 32'h4;
    settle(); tick();
    in_fetch_valid = 0;
    #2;
    rst = 0;
    #1;
    checks++;
    if (obs !== 5'b00000 || cnts !== 15'd0 || out_dec_instr !== 32'd0) begin
      errors++; $display("FAIL async_reset: obs %b cnts %h instr %h expected 00000 0 0", obs, cnts, out_dec_instr);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    int         sel;
    logic [31:0] ins;
    ops = '{7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33, 7'h7F};
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      sel = $urandom_range(0, 10);
      ins = $urandom;
      ins[6:0] = (sel == 10) ? 7'($urandom) : ops[sel];
      in_fetch_valid   = ($urandom_range(0, 9) < 8);
      in_fetch_instr   = ins;
      in_fetch_pc      = $urandom;
      in_fetch_jump_ce = $urandom_range(0, 1) == 1;
      rdy              = ($urandom_range(0, 9) != 0);
      in_flush         = ($urandom_range(0, 39) == 0);
      in_rob_commit    = (m_rob > 0) && ($urandom_range(0, 3) == 0);
      in_rs_release    = (m_rs  > 0) && ($urandom_range(0, 3) == 0);
      in_slb_release   = (m_slb > 0) && ($urandom_range(0, 3) == 0);
      settle();
      checks++;
      if (obs !== {e_ready, e_rob, e_rs, e_slb, e_stall}) begin
        errors++; $display("FAIL rand_outputs[%0d]: got %b expected %b", c, obs, {e_ready, e_rob, e_rs, e_slb, e_stall});
      end
      checks++;
      if (cnts !== {5'(m_rob), 5'(m_rs), 5'(m_slb)}) begin
        errors++; $display("FAIL rand_counts[%0d]: got %h expected %h", c, cnts, {5'(m_rob), 5'(m_rs), 5'(m_slb)});
      end
      if (m_held) begin
        checks++;
        if (out_dec_instr !== m_instr || out_dec_pc !== m_pc || out_dec_jump_ce !== m_jump) begin
          errors++; $display("FAIL rand_held[%0d]: got %h/%h/%b expected %h/%h/%b", c, out_dec_instr, out_dec_pc, out_dec_jump_ce, m_instr, m_pc, m_jump);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_rdy_freeze();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
